// File: rtl/rv_isa_pkg.sv
`include "isa.svh"
`default_nettype none
// ============================================================================
// Module : rv_isa_pkg
// Brief  : RV32I formats, opcodes, field packing and immediate legality check.
// Rev    : 1.0 - initial release
// ============================================================================
package rv_isa_pkg;

    localparam int XLEN    = `RV_XLEN;
    localparam int IR_SIZE = `RV_IR_SIZE;
    localparam int OP_SIZE = `RV_OPCODE_SIZE;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } rv_fmt_e;

    localparam logic [OP_SIZE-1:0] OP_LUI    = 7'h37;
    localparam logic [OP_SIZE-1:0] OP_AUIPC  = 7'h17;
    localparam logic [OP_SIZE-1:0] OP_JAL    = 7'h6F;
    localparam logic [OP_SIZE-1:0] OP_JALR   = 7'h67;
    localparam logic [OP_SIZE-1:0] OP_BRANCH = 7'h63;
    localparam logic [OP_SIZE-1:0] OP_LOAD   = 7'h03;
    localparam logic [OP_SIZE-1:0] OP_STORE  = 7'h23;
    localparam logic [OP_SIZE-1:0] OP_IMM    = 7'h13;
    localparam logic [OP_SIZE-1:0] OP_REG    = 7'h33;

    // fmt kept as raw bits so the illegal codes 6/7 can be represented.
    typedef struct packed {
        logic [2:0]         fmt;
        logic [OP_SIZE-1:0] opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [XLEN-1:0]    imm;
    } rv_req_t;

    function automatic logic [IR_SIZE-1:0] rv_pack(input rv_req_t r);
        logic [IR_SIZE-1:0] ir;
        ir = '0;
        case (r.fmt)
            FMT_R:   ir = {r.funct7, r.rs2, r.rs1, r.funct3, r.rd, r.opcode};
            FMT_I:   ir = {r.imm[11:0], r.rs1, r.funct3, r.rd, r.opcode};
            FMT_S:   ir = {r.imm[11:5], r.rs2, r.rs1, r.funct3, r.imm[4:0], r.opcode};
            FMT_B:   ir = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.funct3,
                           r.imm[4:1], r.imm[11], r.opcode};
            FMT_U:   ir = {r.imm[31:12], r.rd, r.opcode};
            FMT_J:   ir = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12],
                           r.rd, r.opcode};
            default: ir = '0;
        endcase
        return ir;
    endfunction

    // High when the immediate cannot be represented or the opcode is not 32-bit.
    function automatic logic rv_chk(input rv_req_t r);
        logic err;
        err = 1'b0;
        case (r.fmt)
            FMT_R:        err = 1'b0;
            FMT_I, FMT_S: err = !((&r.imm[31:11]) || !(|r.imm[31:11]));
            FMT_B:        err = r.imm[0] || !((&r.imm[31:12]) || !(|r.imm[31:12]));
            FMT_J:        err = r.imm[0] || !((&r.imm[31:20]) || !(|r.imm[31:20]));
            FMT_U:        err = |r.imm[11:0];
            default:      err = 1'b1;
        endcase
        if (r.opcode[1:0] != 2'b11) begin
            err = 1'b1;
        end
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isa.svh
`ifndef ISA_SVH
`define ISA_SVH
`default_nettype none
// Base RV32I architectural widths shared by the encoder and its package.
`define RV_XLEN        32
`define RV_IR_SIZE     32
`define RV_OPCODE_SIZE 7
`default_nettype wire
`endif

// File: rtl/rv_enc_fifo.sv
`default_nettype none
// ============================================================================
// Module : rv_enc_fifo
// Brief  : Synchronous FIFO, extra pointer bit for full/empty, async reset.
// Rev    : 1.0 - initial release
// ============================================================================
module rv_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Storage is not reset; gating keeps the head at zero whenever empty.
    assign dout  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/rv32i_isa_enc.sv
`include "isa.svh"
`default_nettype none
// ============================================================================
// Module : rv32i_isa_enc
// Brief  : Streaming RV32I field-to-word encoder with output FIFO and stats.
//          Legality checking compiled in with `define RV_ENC_CHK_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module rv32i_isa_enc
    import rv_isa_pkg::*;
#(
    parameter int OUT_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_vld,
    output logic                       req_rdy,
    input  logic [2:0]                 req_fmt,
    input  logic [`RV_OPCODE_SIZE-1:0] req_opcode,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_rs1,
    input  logic [4:0]                 req_rs2,
    input  logic [2:0]                 req_funct3,
    input  logic [6:0]                 req_funct7,
    input  logic [`RV_XLEN-1:0]        req_imm,
    output logic                       ins_vld,
    input  logic                       ins_rdy,
    output logic [`RV_IR_SIZE-1:0]     ins,
    output logic                       ins_err,
    output logic [CNT_W-1:0]           enc_cnt,
    output logic [CNT_W-1:0]           err_cnt
);
`ifdef RV_ENC_CHK_EN
    localparam int ENT_W = `RV_IR_SIZE + 1;
`else
    localparam int ENT_W = `RV_IR_SIZE;
`endif
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rv_req_t                 w_req;
    logic [`RV_IR_SIZE-1:0]  w_word;
    logic [ENT_W-1:0]        w_din;
    logic [ENT_W-1:0]        w_dout;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_accept;
    logic [CNT_W-1:0]        r_enc_cnt;

    always_comb begin
        w_req        = '0;
        w_req.fmt    = req_fmt;
        w_req.opcode = req_opcode;
        w_req.rd     = req_rd;
        w_req.rs1    = req_rs1;
        w_req.rs2    = req_rs2;
        w_req.funct3 = req_funct3;
        w_req.funct7 = req_funct7;
        w_req.imm    = req_imm;
    end

    assign w_word   = rv_pack(w_req);
    assign req_rdy  = !w_full;
    assign w_accept = req_vld && req_rdy;

    rv_enc_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_accept),
        .din   (w_din),
        .pop   (ins_vld && ins_rdy),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign ins_vld = !w_empty;
    assign ins     = w_dout[`RV_IR_SIZE-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enc_cnt <= '0;
        end else if (w_accept && (r_enc_cnt != {CNT_W{1'b1}})) begin
            r_enc_cnt <= r_enc_cnt + C_CNT_ONE;
        end
    end
    assign enc_cnt = r_enc_cnt;

`ifdef RV_ENC_CHK_EN
    logic             w_err;
    logic [CNT_W-1:0] r_err_cnt;

    assign w_err   = rv_chk(w_req);
    assign w_din   = {w_err, w_word};
    assign ins_err = w_dout[`RV_IR_SIZE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_accept && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + C_CNT_ONE;
        end
    end
    assign err_cnt = r_err_cnt;
`else
    assign w_din   = w_word;
    assign ins_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv32i_isa_enc.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32i_isa_enc
// Brief  : Directed scoreboard bench for rv32i_isa_enc (CNT_W=4, OUT_DEPTH=2).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_rv32i_isa_enc;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_vld = 1'b0;
    logic             req_rdy;
    logic [2:0]       req_fmt = '0;
    logic [6:0]       req_opcode = '0;
    logic [4:0]       req_rd = '0;
    logic [4:0]       req_rs1 = '0;
    logic [4:0]       req_rs2 = '0;
    logic [2:0]       req_funct3 = '0;
    logic [6:0]       req_funct7 = '0;
    logic [31:0]      req_imm = '0;
    logic             ins_vld;
    logic             ins_rdy = 1'b1;
    logic [31:0]      ins;
    logic             ins_err;
    logic [CNT_W-1:0] enc_cnt;
    logic [CNT_W-1:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_err    = 0;
    int n_out    = 0;
    logic [32:0] q [$];

    rv32i_isa_enc #(
        .OUT_DEPTH (2),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_fmt    (req_fmt),
        .req_opcode (req_opcode),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_funct3 (req_funct3),
        .req_funct7 (req_funct7),
        .req_imm    (req_imm),
        .ins_vld    (ins_vld),
        .ins_rdy    (ins_rdy),
        .ins        (ins),
        .ins_err    (ins_err),
        .enc_cnt    (enc_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic exp_err(input logic e);
`ifdef RV_ENC_CHK_EN
        return e;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] sat(input int n);
        return (n > 15) ? 32'd15 : n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ins_vld && ins_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_out", ins, 32'hDEAD_BEEF);
            end else begin
                logic [32:0] e;
                e = q.pop_front();
                chk("ins", ins, e[31:0]);
                chk("ins_err", {31'd0, ins_err}, {31'd0, e[32]});
                n_out++;
            end
        end
    end

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        req_vld = 1'b1;
        req_fmt = fmt;  req_opcode = op;  req_rd = rd;  req_rs1 = rs1;
        req_rs2 = rs2;  req_funct3 = f3;  req_funct7 = f7;  req_imm = imm;
    endtask

    // Expected word and raw error bit come from the caller; accepted on the edge after req_rdy is seen high.
    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] word, input logic err);
        bit done;
        done = 1'b0;
        drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_rdy) begin
                q.push_back({exp_err(err), word});
                n_acc++;
                if (exp_err(err)) n_err++;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        req_vld = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (q.size() == 0 && !ins_vld) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int out0;
        #1;
        chk("rst_ins_vld", {31'd0, ins_vld}, 32'd0);
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_err", {31'd0, ins_err}, 32'd0);
        chk("rst_enc_cnt", {28'd0, enc_cnt}, 32'd0);
        chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // addi x1,x0,5 and one-cycle latency
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        chk("lat_ins_vld", {31'd0, ins_vld}, 32'd1);
        chk("lat_enc_cnt", {28'd0, enc_cnt}, 32'd1);
        @(posedge clk); #1;

        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'h0020_81B3, 1'b0);
        send(3'd4, 7'h37, 5'd5, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020_A423, 1'b0);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0020_00EF, 1'b1);
        drain();
        chk("err_cnt_j", {28'd0, err_cnt}, {31'd0, exp_err(1'b1)});

        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1);
        send(3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h0000_0001, 32'h0000_0000, 1'b1);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h8000_0093, 1'b1);
        send(3'd0, 7'h30, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h0020_81B0, 1'b1);
        drain();
        chk("enc_cnt_mid", {28'd0, enc_cnt}, sat(n_acc));
        chk("err_cnt_mid", {28'd0, err_cnt}, sat(n_err));

        // Backpressure: two fill the FIFO, the third is held until the consumer drains
        ins_rdy = 1'b0;
        send(3'd1, 7'h13, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0513, 1'b0);
        send(3'd1, 7'h13, 5'd11, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0593, 1'b0);
        drive(3'd1, 7'h13, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        chk("bp_req_rdy0", {31'd0, req_rdy}, 32'd0);
        chk("bp_head", ins, 32'h0010_0513);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_req_rdy1", {31'd0, req_rdy}, 32'd0);
        chk("bp_hold", ins, 32'h0010_0513);
        chk("bp_enc_cnt", {28'd0, enc_cnt}, sat(n_acc));
        @(posedge clk); #1;
        ins_rdy = 1'b1;
        send(3'd1, 7'h13, 5'd12, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0613, 1'b0);
        drain();

        // Saturation
        while (n_acc < 17) begin
            send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        end
        drain();
        chk("enc_cnt_sat", {28'd0, enc_cnt}, 32'h0000_000F);
        chk("err_cnt_end", {28'd0, err_cnt}, sat(n_err));

        // Asynchronous reset with two entries queued
        ins_rdy = 1'b0;
        send(3'd1, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0393, 1'b0);
        send(3'd1, 7'h13, 5'd8, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_0413, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_ins_vld", {31'd0, ins_vld}, 32'd0);
        chk("arst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("arst_enc_cnt", {28'd0, enc_cnt}, 32'd0);
        chk("arst_err_cnt", {28'd0, err_cnt}, 32'd0);
        q.delete();
        n_acc = 0;
        n_err = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        ins_rdy = 1'b1;
        out0 = n_out;
        send(3'd1, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0493, 1'b0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_outs", n_out - out0, 32'd1);
        chk("post_rst_enc_cnt", {28'd0, enc_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
